// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch PCs, reads a word store, and returns
// in-order responses after LATENCY cycles through a credit-protected FWFT FIFO.
module imem_responder #(
   parameter int MEM_WORDS = 256,
   parameter int LATENCY   = 1,
   parameter int DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [31:0] rsp_addr,
   output logic        rsp_err,
   input  logic        prog_we,
   input  logic [31:0] prog_addr,
   input  logic [31:0] prog_data
);
   localparam int IW = $clog2(MEM_WORDS);
   localparam int AW = $clog2(DEPTH);
   localparam int ST = (LATENCY > 1) ? LATENCY - 1 : 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic [31:0] mem [MEM_WORDS];
   rsp_t        fifo [DEPTH];
   logic [AW:0] cnt, wr_ptr, rd_ptr;
   logic        acc, cns, push, prog_ok;
   rsp_t        in_ent, push_ent, head;
   logic        unused_prog_lsb;

   assign unused_prog_lsb = ^prog_addr[1:0];

   // Credit count covers both in-flight pipeline entries and FIFO contents,
   // so the FIFO can never overflow and nothing downstream needs to stall.
   assign req_ready = !rst && (cnt < (AW+1)'(DEPTH));
   assign rsp_valid = !rst && (wr_ptr != rd_ptr);
   assign acc       = req_valid && req_ready;
   assign cns       = rsp_valid && rsp_ready;

   // Asynchronous read sampled at the accept edge gives read-before-write.
   always_comb begin
      in_ent      = '0;
      in_ent.addr = req_addr;
      in_ent.err  = (req_addr[1:0] != 2'b00) || ((req_addr >> (IW + 2)) != 32'd0);
      in_ent.data = in_ent.err ? NOP : mem[req_addr[IW+1:2]];
   end

   assign prog_ok = (prog_addr >> (IW + 2)) == 32'd0;

   always_ff @(posedge clk) begin
      if (prog_we && prog_ok) mem[prog_addr[IW+1:2]] <= prog_data;
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign push     = acc;
         assign push_ent = in_ent;
      end else begin : g_pipe
         logic [ST:1] vld_pipe;
         rsp_t        pipe [ST:1];

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_pipe <= '0;
            end else begin
               vld_pipe[1] <= acc;
               for (int k = 2; k <= ST; k++) vld_pipe[k] <= vld_pipe[k-1];
            end
         end

         always_ff @(posedge clk) begin
            pipe[1] <= in_ent;
            for (int k = 2; k <= ST; k++) pipe[k] <= pipe[k-1];
         end

         assign push     = vld_pipe[ST];
         assign push_ent = pipe[ST];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr[AW-1:0]] <= push_ent;
            wr_ptr               <= wr_ptr + 1'b1;
         end
         if (cns) rd_ptr <= rd_ptr + 1'b1;
         case ({acc, cns})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   assign head     = fifo[rd_ptr[AW-1:0]];
   assign rsp_data = rsp_valid ? head.data : 32'd0;
   assign rsp_addr = rsp_valid ? head.addr : 32'd0;
   assign rsp_err  = rsp_valid && head.err;
endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder: LATENCY=1 and LATENCY=3 instances checked
// cycle by cycle against a queue-based model of outstanding responses.
module tb_imem_responder;
   localparam int MW    = 256;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, sel;
   logic        req_valid, rsp_ready, prog_we;
   logic [31:0] req_addr, prog_addr, prog_data;

   logic        rr1, rv1, re1, rr3, rv3, re3;
   logic [31:0] rd1, ra1, rd3, ra3;
   logic        d_ready, d_valid, d_err;
   logic [31:0] d_data, d_addr;

   always #5 clk = ~clk;

   imem_responder #(.MEM_WORDS(MW), .LATENCY(1), .DEPTH(DEPTH)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && !sel), .req_ready(rr1), .req_addr(req_addr),
      .rsp_valid(rv1), .rsp_ready(rsp_ready || sel), .rsp_data(rd1), .rsp_addr(ra1), .rsp_err(re1),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

   imem_responder #(.MEM_WORDS(MW), .LATENCY(3), .DEPTH(DEPTH)) u_dut3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && sel), .req_ready(rr3), .req_addr(req_addr),
      .rsp_valid(rv3), .rsp_ready(rsp_ready || !sel), .rsp_data(rd3), .rsp_addr(ra3), .rsp_err(re3),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

   assign d_ready = sel ? rr3 : rr1;
   assign d_valid = sel ? rv3 : rv1;
   assign d_data  = sel ? rd3 : rd1;
   assign d_addr  = sel ? ra3 : ra1;
   assign d_err   = sel ? re3 : re1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      int          elig;
   } exp_t;

   exp_t        q[$];
   logic [31:0] ref_mem [MW];
   int          n_tests = 0, n_fail = 0, cyc = 0;
   logic        last_acc;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: check outputs at the falling edge, then advance the model across the rising edge.
   task automatic step();
      logic exp_v, exp_rdy, acc, cns;
      exp_t e;
      int   lat;
      lat = sel ? 3 : 1;
      @(negedge clk);
      exp_v   = !rst && q.size() > 0 && cyc >= q[0].elig;
      exp_rdy = !rst && q.size() < DEPTH;
      chk("rsp_valid", 32'(d_valid), 32'(exp_v));
      chk("req_ready", 32'(d_ready), 32'(exp_rdy));
      if (exp_v && d_valid) begin
         chk("rsp_data", d_data, q[0].data);
         chk("rsp_addr", d_addr, q[0].addr);
         chk("rsp_err", 32'(d_err), 32'(q[0].err));
      end
      if (rst) begin
         chk("rst_data", d_data, 32'd0);
         chk("rst_addr", d_addr, 32'd0);
         chk("rst_err", 32'(d_err), 32'd0);
      end
      acc = req_valid && exp_rdy;
      cns = rsp_ready && exp_v;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (cns) void'(q.pop_front());
         if (acc) begin
            e.addr = req_addr;
            e.err  = (req_addr % 4 != 0) || (req_addr >= 4 * MW);
            e.data = e.err ? 32'h13 : ref_mem[req_addr / 4];
            e.elig = cyc + lat;
            q.push_back(e);
         end
      end
      if (prog_we && prog_addr < 4 * MW) ref_mem[prog_addr / 4] = prog_data;
      last_acc = acc;
      cyc++;
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      prog_we   = 1'b0;
   endtask

   task automatic prog(input logic [31:0] a, input logic [31:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      step();
      prog_we = 1'b0;
   endtask

   task automatic req(input logic [31:0] a);
      req_valid = 1'b1; req_addr = a;
      step();
   endtask

   task automatic drain();
      idle();
      rsp_ready = 1'b1;
      repeat (DEPTH + 6) step();
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
         1:       return 32'h400 + (32'($urandom_range(0, 4095)) << 2);
         2:       return 32'h3FC;
         default: return 32'($urandom_range(0, 255)) << 2;
      endcase
   endfunction

   task automatic random_steps(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_addr  = rand_addr();
         rsp_ready = ($urandom_range(0, 3) != 0);
         prog_we   = ($urandom_range(0, 7) == 0);
         prog_addr = ($urandom_range(0, 5) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                                 : (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
         prog_data = $urandom;
         step();
      end
   endtask

   logic [31:0] a2 [5];
   int          k;

   initial begin
      sel = 1'b0; rst = 1'b1; rsp_ready = 1'b0;
      idle(); req_addr = '0; prog_addr = '0; prog_data = '0;
      repeat (2) step();
      rst = 1'b0;

      for (int i = 0; i < MW; i++) prog(32'(i) << 2, $urandom);
      prog(32'h0, 32'h11); prog(32'h4, 32'h22); prog(32'h8, 32'h33); prog(32'hC, 32'h44);
      prog(32'h10, 32'h55);

      // back-to-back fetches, one response per cycle
      rsp_ready = 1'b1;
      req(32'h0); req(32'h4); req(32'h8); req(32'hC);
      drain();

      // fill to DEPTH with the consumer stalled, then release
      a2 = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};
      rsp_ready = 1'b0; req_valid = 1'b1; k = 0;
      for (int s = 0; s < 8; s++) begin
         req_addr = a2[k];
         step();
         if (last_acc) k++;
      end
      chk("t2_accepted_full", 32'(k), 32'd4);
      rsp_ready = 1'b1;
      for (int s = 0; s < 20 && k < 5; s++) begin
         req_addr = a2[k];
         step();
         if (last_acc) k++;
      end
      chk("t2_fifth_accepted", 32'(k), 32'd5);
      drain();

      // misaligned, out of range, last word
      req(32'h2); req(32'h400); req(32'h3FC);
      drain();

      // read-before-write on the same edge, then dropped out-of-range program write
      prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'hDEADBEEF;
      req(32'h10);
      prog_we = 1'b0;
      req(32'h10);
      idle();
      prog(32'h400, 32'hBAD0BAD0);
      req(32'h0);
      drain();

      // reset with requests outstanding
      rsp_ready = 1'b0;
      req(32'h0); req(32'h4); req(32'h8);
      idle();
      rst = 1'b1; step(); rst = 1'b0;
      repeat (4) step();
      rsp_ready = 1'b1;
      req(32'h0);
      drain();

      random_steps(300);
      drain();

      // LATENCY=3 instance
      sel = 1'b1;
      req(32'h8);
      idle();
      repeat (5) step();
      for (int i = 0; i < 6; i++) req(32'(i) << 2);
      drain();
      random_steps(300);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
